// File: rtl/lab2_proc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_mem_responder_if
// Brief    : val/rdy request/response bundle for the 4-byte memory protocol.
// Revision : 1.0 - initial release
// ============================================================================
interface lab2_proc_mem_responder_if;
  // req  = {type_[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
  // resp = {type_[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
  logic [76:0] memreq_msg;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [46:0] memresp_msg;
  logic        memresp_val;
  logic        memresp_rdy;

  modport master (
    output memreq_msg, memreq_val, memresp_rdy,
    input  memreq_rdy, memresp_msg, memresp_val
  );

  modport slave (
    input  memreq_msg, memreq_val, memresp_rdy,
    output memreq_rdy, memresp_msg, memresp_val
  );
endinterface
`default_nettype wire

// File: rtl/lab2_proc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_mem_responder
// Brief    : Word-addressed memory responder with fixed latency and buffered
//            responses. Optional: LAB2_PROC_MEM_RESPONDER_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lab2_proc_mem_responder #(
  parameter int p_mem_nwords = 256,
  parameter int p_lat        = 1,
  parameter int p_max_outst  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  lab2_proc_mem_responder_if.slave    bus
);

  localparam int c_aw = $clog2(p_mem_nwords);
  localparam int c_cw = $clog2(p_max_outst + 1);
  localparam int c_pw = (p_max_outst > 1) ? $clog2(p_max_outst) : 1;
  localparam logic [c_cw-1:0] c_max = c_cw'(p_max_outst);

  logic [2:0]      w_type;
  logic [7:0]      w_opq;
  logic [31:0]     w_addr;
  logic [1:0]      w_len;
  logic [31:0]     w_data;
  logic [c_aw-1:0] w_widx;
  logic            w_oob;
  logic            w_is_wr;
  logic [3:0]      w_be;
  logic [4:0]      w_shift;
  logic [31:0]     w_rmask;
  logic [31:0]     w_word;
  logic [31:0]     w_rdata;
  logic [31:0]     w_wdata;
  logic [46:0]     w_resp;
  logic            w_req_rdy;
  logic            w_req_fire;
  logic            w_enq;
  logic [46:0]     w_enq_msg;
  logic            w_empty;
  logic            w_full;
  logic            w_deq;

  logic [31:0]     r_mem [p_mem_nwords];
  logic [46:0]     r_fifo [p_max_outst];
  logic [c_pw:0]   r_wr;
  logic [c_pw:0]   r_rd;
  logic [c_cw-1:0] r_outst;
  logic            r_active;

  assign w_type = bus.memreq_msg[76:74];
  assign w_opq  = bus.memreq_msg[73:66];
  assign w_addr = bus.memreq_msg[65:34];
  assign w_len  = bus.memreq_msg[33:32];
  assign w_data = bus.memreq_msg[31:0];
  assign w_widx = w_addr[c_aw+1:2];

`ifdef LAB2_PROC_MEM_RESPONDER_BOUNDS_CHECK_EN
  assign w_oob = (33'(w_addr) >= (33'(p_mem_nwords) * 33'd4));
`else
  assign w_oob = 1'b0;
  // Upper address bits are deliberately dropped so accesses wrap.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, w_addr[31:c_aw+2]};
`endif

  assign w_req_rdy      = r_active && (r_outst < c_max);
  assign w_req_fire     = bus.memreq_val && w_req_rdy;
  assign bus.memreq_rdy = w_req_rdy;

  always_comb begin
    w_be    = 4'b1111;
    w_shift = 5'd0;
    w_rmask = 32'hFFFF_FFFF;
    case (w_len)
      2'd1: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_shift = {w_addr[1:0], 3'b000};
        w_rmask = 32'h0000_00FF;
      end
      2'd2: begin
        w_be    = 4'b0011 << {w_addr[1], 1'b0};
        w_shift = {w_addr[1], 4'b0000};
        w_rmask = 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

  assign w_is_wr = (w_type == 3'd1) || (w_type == 3'd2);
  assign w_word  = r_mem[w_widx];
  assign w_rdata = (w_is_wr || w_oob) ? 32'd0 : ((w_word >> w_shift) & w_rmask);
  assign w_wdata = w_data << w_shift;
  assign w_resp  = {w_type, w_opq, (w_oob ? 2'b01 : 2'b00), w_len, w_rdata};

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_req_fire && w_is_wr && !w_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // The fire cycle itself is the first latency stage.
  generate
    if (p_lat == 1) begin : g_lat_one
      assign w_enq     = w_req_fire;
      assign w_enq_msg = w_resp;
    end else begin : g_lat_pipe
      logic        r_pv [p_lat-1];
      logic [46:0] r_pm [p_lat-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < p_lat-1; i++) r_pv[i] <= 1'b0;
        end else begin
          r_pv[0] <= w_req_fire;
          for (int i = 1; i < p_lat-1; i++) r_pv[i] <= r_pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        r_pm[0] <= w_resp;
        for (int i = 1; i < p_lat-1; i++) r_pm[i] <= r_pm[i-1];
      end

      assign w_enq     = r_pv[p_lat-2];
      assign w_enq_msg = r_pm[p_lat-2];
    end
  endgenerate

  function automatic logic [c_pw:0] f_ptr_inc(input logic [c_pw:0] p);
    if (p[c_pw-1:0] == c_pw'(p_max_outst - 1)) return {~p[c_pw], {c_pw{1'b0}}};
    else                                       return p + (c_pw+1)'(1);
  endfunction

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[c_pw] != r_rd[c_pw]) && (r_wr[c_pw-1:0] == r_rd[c_pw-1:0]);
  assign w_deq   = !w_empty && bus.memresp_rdy;

  assign bus.memresp_val = !w_empty;
  assign bus.memresp_msg = w_empty ? 47'd0 : r_fifo[r_rd[c_pw-1:0]];

  always_ff @(posedge clk) begin
    if (w_enq) r_fifo[r_wr[c_pw-1:0]] <= w_enq_msg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_outst  <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_enq) r_wr <= f_ptr_inc(r_wr);
      if (w_deq) r_rd <= f_ptr_inc(r_rd);
      case ({w_req_fire, w_deq})
        2'b10:   r_outst <= r_outst + c_cw'(1);
        2'b01:   r_outst <= r_outst - c_cw'(1);
        default: ;
      endcase
    end
  end

  // The outstanding limit must make an enqueue into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
                                   !(w_enq && w_full && !w_deq));

endmodule
`default_nettype wire

// File: tb/tb_lab2_proc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab2_proc_mem_responder
// Brief    : Directed + random checks of two responder instances (lat 1 / 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab2_proc_mem_responder;

  localparam int c_lat_a = 1;
  localparam int c_lat_b = 3;
  localparam int c_max   = 4;

  logic        clk = 1'b0;
  logic        reset;
  int          sel;
  logic [76:0] req_msg;
  logic        req_val;
  logic        resp_rdy;

  always #5 clk = ~clk;

  lab2_proc_mem_responder_if ifa ();
  lab2_proc_mem_responder_if ifb ();

  assign ifa.memreq_msg  = req_msg;
  assign ifa.memreq_val  = req_val && (sel == 0);
  assign ifa.memresp_rdy = (sel == 0) ? resp_rdy : 1'b1;
  assign ifb.memreq_msg  = req_msg;
  assign ifb.memreq_val  = req_val && (sel == 1);
  assign ifb.memresp_rdy = (sel == 1) ? resp_rdy : 1'b1;

  lab2_proc_mem_responder #(.p_mem_nwords(256), .p_lat(c_lat_a), .p_max_outst(c_max))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  lab2_proc_mem_responder #(.p_mem_nwords(256), .p_lat(c_lat_b), .p_max_outst(c_max))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  logic        w_req_rdy;
  logic        w_resp_val;
  logic [46:0] w_resp_msg;
  assign w_req_rdy  = (sel == 0) ? ifa.memreq_rdy  : ifb.memreq_rdy;
  assign w_resp_val = (sel == 0) ? ifa.memresp_val : ifb.memresp_val;
  assign w_resp_msg = (sel == 0) ? ifa.memresp_msg : ifb.memresp_msg;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          act     = 1'b0;
  bit          req_fired;

  logic [7:0]  mb [2][1024];
  logic [46:0] qm [2][$];
  int          qd [2][$];
  int          acc_cyc  [256];
  int          fire_cyc [256];
  logic [31:0] rdat     [256];
  logic [1:0]  rtest    [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [76:0] mk(input logic [2:0] t, input logic [7:0] o,
                                     input logic [31:0] a, input logic [1:0] l,
                                     input logic [31:0] d);
    return {t, o, a, l, d};
  endfunction

  // Reference: byte-addressed storage, len/offset rules applied byte by byte.
  function automatic logic [46:0] model(input int d, input logic [76:0] r);
    logic [2:0]  t;
    logic [31:0] a;
    logic [1:0]  l;
    logic [31:0] rd;
    logic        oob;
    int          nb, base, ba;
    t  = r[76:74];
    a  = r[65:34];
    l  = r[33:32];
    rd = 32'd0;
`ifdef LAB2_PROC_MEM_RESPONDER_BOUNDS_CHECK_EN
    oob = (a >= 32'd1024);
`else
    oob = 1'b0;
`endif
    nb   = (l == 2'd1) ? 1 : (l == 2'd2) ? 2 : 4;
    base = (l == 2'd1) ? int'(a[1:0]) : (l == 2'd2) ? 2 * int'(a[1]) : 0;
    ba   = 4 * int'(a[9:2]) + base;
    if (!oob) begin
      for (int i = 0; i < nb; i++) begin
        if (t == 3'd1 || t == 3'd2) mb[d][ba+i] = r[8*i +: 8];
        else                        rd = rd | (32'(mb[d][ba+i]) << (8*i));
      end
    end
    return {t, r[73:66], (oob ? 2'b01 : 2'b00), l, rd};
  endfunction

  function automatic logic [76:0] rand_req();
    logic [2:0] t;
    t = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
    return mk(t, 8'($urandom), 32'($urandom_range(0, 32'h4FF)), 2'($urandom_range(0, 3)), $urandom);
  endfunction

  // Evaluate one cycle just before its rising edge, then advance to the next falling edge.
  task automatic tick();
    logic [46:0] em;
    bit          ev;
    #1;
    req_fired = 1'b0;
    if (!reset) begin
      chk("rst_resp_val", 64'(w_resp_val), 64'd0);
      chk("rst_req_rdy",  64'(w_req_rdy),  64'd0);
      chk("rst_resp_msg", 64'(w_resp_msg), 64'd0);
    end else begin
      ev = (qm[sel].size() > 0) && (qd[sel][0] <= cyc);
      chk("resp_val", 64'(w_resp_val), 64'(ev));
      if (act) chk("req_rdy", 64'(w_req_rdy), 64'(qm[sel].size() < c_max));
      if (ev && w_resp_val) chk("resp_msg", 64'(w_resp_msg), 64'(qm[sel][0]));
      if (w_resp_val && resp_rdy && qm[sel].size() > 0) begin
        em = qm[sel].pop_front();
        void'(qd[sel].pop_front());
        fire_cyc[em[43:36]] = cyc;
        rdat[em[43:36]]     = w_resp_msg[31:0];
        rtest[em[43:36]]    = w_resp_msg[35:34];
      end
      if (req_val && w_req_rdy) begin
        req_fired = 1'b1;
        acc_cyc[req_msg[73:66]] = cyc;
        qm[sel].push_back(model(sel, req_msg));
        qd[sel].push_back(cyc + ((sel == 0) ? c_lat_a : c_lat_b));
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [76:0] m);
    int n;
    n = 0;
    req_msg   = m;
    req_val   = 1'b1;
    req_fired = 1'b0;
    while (!req_fired && n < 64) begin
      tick();
      n++;
    end
    chk("accept", 64'(req_fired), 64'd1);
    req_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qm[0].size() + qm[1].size()) > 0 && n < 400) begin
      tick();
      n++;
    end
    chk("drain", 64'(qm[0].size() + qm[1].size()), 64'd0);
  endtask

  initial begin
    int k, n;
    reset    = 1'b0;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b1;
    sel      = 0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b1;
    tick();
    act = 1'b1;

    // Fill both storage arrays with known random words.
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int w = 0; w < 256; w++) send(mk(3'd2, 8'(w), 32'(w * 4), 2'd0, $urandom));
      drain();
    end
    sel = 0;

    // Write then read, latency 1.
    send(mk(3'd1, 8'h03, 32'h10, 2'd0, 32'hDEADBEEF));
    send(mk(3'd0, 8'h04, 32'h10, 2'd0, 32'd0));
    drain();
    chk("wr_resp_data", 64'(rdat[8'h03]), 64'd0);
    chk("rd_resp_data", 64'(rdat[8'h04]), 64'hDEADBEEF);
    chk("lat1_first",   64'(fire_cyc[8'h03] - acc_cyc[8'h03]), 64'd1);
    chk("lat1_consec",  64'(fire_cyc[8'h04] - fire_cyc[8'h03]), 64'd1);

    // Sub-word accesses.
    send(mk(3'd0, 8'h05, 32'h12, 2'd1, 32'd0));
    send(mk(3'd0, 8'h06, 32'h12, 2'd2, 32'd0));
    send(mk(3'd1, 8'h07, 32'h11, 2'd1, 32'h55));
    send(mk(3'd0, 8'h08, 32'h10, 2'd0, 32'd0));
    drain();
    chk("byte_rd",  64'(rdat[8'h05]), 64'h000000AD);
    chk("half_rd",  64'(rdat[8'h06]), 64'h0000DEAD);
    chk("byte_wr",  64'(rdat[8'h08]), 64'hDEAD55EF);

    // Backpressure: only four requests may be outstanding.
    resp_rdy = 1'b0;
    k = 0;
    n = 0;
    while (k < 6 && n < 12) begin
      req_msg = mk(3'd0, 8'(8'h20 + k), 32'(4 * k), 2'd0, 32'd0);
      req_val = 1'b1;
      tick();
      if (req_fired) k++;
      n++;
    end
    chk("bp_accepted", 64'(k), 64'd4);
    chk("bp_rdy_low",  64'(w_req_rdy), 64'd0);
    resp_rdy = 1'b1;
    while (k < 6 && n < 40) begin
      req_msg = mk(3'd0, 8'(8'h20 + k), 32'(4 * k), 2'd0, 32'd0);
      req_val = 1'b1;
      tick();
      if (req_fired) k++;
      n++;
    end
    req_val = 1'b0;
    chk("bp_all_accepted", 64'(k), 64'd6);
    drain();
    for (int i = 1; i < 6; i++) chk("bp_order", 64'(fire_cyc[8'h20+i] > fire_cyc[8'h20+i-1]), 64'd1);
    chk("bp_refill_after_resp", 64'(acc_cyc[8'h24] > fire_cyc[8'h20]), 64'd1);

    // Out-of-range / wrap behaviour.
    send(mk(3'd1, 8'h30, 32'h000, 2'd0, 32'h12345678));
    send(mk(3'd1, 8'h31, 32'h400, 2'd0, 32'h00000001));
    send(mk(3'd0, 8'h32, 32'h000, 2'd0, 32'd0));
    drain();
    chk("inrange_test", 64'(rtest[8'h30]), 64'd0);
`ifdef LAB2_PROC_MEM_RESPONDER_BOUNDS_CHECK_EN
    chk("oob_test",     64'(rtest[8'h31]), 64'd1);
    chk("oob_no_write", 64'(rdat[8'h32]),  64'h12345678);
`else
    chk("wrap_test",    64'(rtest[8'h31]), 64'd0);
    chk("wrap_write",   64'(rdat[8'h32]),  64'h00000001);
`endif

    // Reset with three requests in flight.
    resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(3'd0, 8'(8'h40 + i), 32'h10, 2'd0, 32'd0));
    reset = 1'b0;
    #1;
    chk("rst_now_val", 64'(w_resp_val), 64'd0);
    chk("rst_now_rdy", 64'(w_req_rdy),  64'd0);
    qm[0].delete();
    qd[0].delete();
    act = 1'b0;
    tick();
    reset    = 1'b1;
    resp_rdy = 1'b1;
    tick();
    act = 1'b1;
    repeat (8) tick();
    send(mk(3'd0, 8'h43, 32'h10, 2'd0, 32'd0));
    drain();
    chk("storage_kept", 64'(rdat[8'h43]), 64'hDEAD55EF);

    // Latency 3, back-to-back reads.
    sel = 1;
    for (int i = 0; i < 8; i++) send(mk(3'd0, 8'(8'h50 + i), 32'($urandom_range(0, 1023)), 2'd0, 32'd0));
    drain();
    chk("lat3_first",  64'(fire_cyc[8'h50] - acc_cyc[8'h50]), 64'd3);
    chk("lat3_accept", 64'(acc_cyc[8'h57] - acc_cyc[8'h50]), 64'd7);
    for (int i = 1; i < 8; i++) chk("lat3_stream", 64'(fire_cyc[8'h50+i] - fire_cyc[8'h50]), 64'(i));

    // Random traffic with random backpressure on both instances.
    for (int d = 0; d < 2; d++) begin
      sel = d;
      req_val = 1'b0;
      repeat (600) begin
        if (!req_val || req_fired) begin
          req_msg = rand_req();
          req_val = ($urandom_range(0, 3) != 0);
        end
        resp_rdy = ($urandom_range(0, 3) != 0);
        tick();
      end
      req_val  = 1'b0;
      resp_rdy = 1'b1;
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
